// File: rtl/regfile_sb.sv
// Multi-port register file with per-register pending-write scoreboard and optional write bypass.
// Latency: reads, busy and iss_ready are combinational; write/issue effects and pend_cnt appear one edge later.
// Backpressure: iss_ready drops on a WAW hazard and issues are ignored until the old producer retires.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRP      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NRP*AW-1:0]  rs_addr,
  output logic [NRP*XLEN-1:0] rs_data,
  output logic [NRP-1:0]     rs_busy,
  input  logic               we,
  input  logic [AW-1:0]      rd,
  input  logic [XLEN-1:0]    wdata,
  input  logic               iss_valid,
  input  logic [AW-1:0]      iss_rd,
  output logic               iss_ready,
  output logic [AW:0]        pend_cnt
);

  localparam logic [AW:0] NREG_L = (AW+1)'(NREG);

  logic [XLEN-1:0] x [NREG];
  logic [NREG-1:0] pend;

  logic wr_hit;
  logic iss_mark;
  logic iss_pend;
  logic wr_pend;
  logic cnt_set;
  logic cnt_clr;

  // A register can hold state only if it exists and is not the hardwired zero
  function automatic logic markable(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Scoreboard decode: hazard check, accepted issue, and counter deltas
  always_comb begin
    iss_pend = 1'b0;
    wr_pend  = 1'b0;
    if (markable(iss_rd)) iss_pend = pend[iss_rd];
    if (markable(rd))     wr_pend  = pend[rd];
    wr_hit    = we && markable(rd);
    // Unmarkable destinations never stall; a same-cycle retire lifts a WAW stall
    iss_ready = !iss_pend || (we && (rd == iss_rd));
    iss_mark  = iss_valid && iss_ready && markable(iss_rd);
    // Count only real transitions of pending bits so pend_cnt equals their population
    cnt_set   = iss_mark && !iss_pend;
    cnt_clr   = wr_hit && wr_pend && !(iss_mark && (iss_rd == rd));
  end

  // Register storage: writeback updates the architectural value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) x[i] <= '0;
    end else if (wr_hit) begin
      x[rd] <= wdata;
    end
  end

  // Pending bits: writeback clears, accepted issue sets; set is applied last so it wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= '0;
    end else begin
      if (wr_hit)   pend[rd]     <= 1'b0;
      if (iss_mark) pend[iss_rd] <= 1'b1;
    end
  end

  // Running count of pending registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_cnt <= '0;
    end else if (cnt_set != cnt_clr) begin
      if (cnt_set) pend_cnt <= pend_cnt + 1'b1;
      else         pend_cnt <= pend_cnt - 1'b1;
    end
  end

  // Read ports: zero/out-of-range reads give 0, bypass forwards in-flight writeback data
  for (genvar p = 0; p < NRP; p++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;

    assign a = rs_addr[p*AW +: AW];

    // Per-port operand and hazard selection
    always_comb begin
      d = '0;
      b = 1'b0;
      if (markable(a)) begin
        if ((BYPASS != 0) && we && (rd == a)) begin
          d = wdata;
        end else begin
          d = x[a];
          b = pend[a];
        end
      end
    end

    assign rs_data[p*XLEN +: XLEN] = d;
    assign rs_busy[p]              = b;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus random traffic against a behavioural model.
// Latency: checks comb outputs mid-cycle and registered state after each edge.
// Backpressure: random issues may be refused; the model predicts iss_ready independently.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic b_reset = 1'b1;

  // Default instance: XLEN=32, NREG=32, NRP=2, BYPASS=1, ZERO_REG=1
  logic [9:0]  a_rs_addr = '0;
  logic [63:0] a_rs_data;
  logic [1:0]  a_rs_busy;
  logic        a_we = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_wdata = '0;
  logic        a_iss_valid = 1'b0;
  logic [4:0]  a_iss_rd = '0;
  logic        a_iss_ready;
  logic [5:0]  a_pend_cnt;

  // Swept instance: XLEN=64, NREG=16, NRP=4, BYPASS=0, ZERO_REG=0
  logic [15:0]  b_rs_addr = '0;
  logic [255:0] b_rs_data;
  logic [3:0]   b_rs_busy;
  logic         b_we = 1'b0;
  logic [3:0]   b_rd = '0;
  logic [63:0]  b_wdata = '0;
  logic         b_iss_valid = 1'b0;
  logic [3:0]   b_iss_rd = '0;
  logic         b_iss_ready;
  logic [4:0]   b_pend_cnt;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] BASE = 64'h0123_4567_89AB_0000;

  regfile_sb u0 (
    .clk(clk), .reset(reset),
    .rs_addr(a_rs_addr), .rs_data(a_rs_data), .rs_busy(a_rs_busy),
    .we(a_we), .rd(a_rd), .wdata(a_wdata),
    .iss_valid(a_iss_valid), .iss_rd(a_iss_rd), .iss_ready(a_iss_ready),
    .pend_cnt(a_pend_cnt)
  );

  regfile_sb #(.XLEN(64), .NREG(16), .NRP(4), .BYPASS(0), .ZERO_REG(0)) u1 (
    .clk(clk), .reset(b_reset),
    .rs_addr(b_rs_addr), .rs_data(b_rs_data), .rs_busy(b_rs_busy),
    .we(b_we), .rd(b_rd), .wdata(b_wdata),
    .iss_valid(b_iss_valid), .iss_rd(b_iss_rd), .iss_ready(b_iss_ready),
    .pend_cnt(b_pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of u0: plain arrays of values and pending flags
  logic [31:0] mx [32];
  bit          mp [32];

  initial begin
    for (int i = 0; i < 32; i++) begin
      mx[i] = '0;
      mp[i] = 1'b0;
    end
  end

  function automatic bit m_ready(input logic [4:0] r);
    return (r == 0) || !mp[r] || (a_we && a_rd == r);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mx[i] = '0;
        mp[i] = 1'b0;
      end
    end else begin
      bit acc;
      acc = a_iss_valid && m_ready(a_iss_rd) && (a_iss_rd != 0);
      if (a_we && a_rd != 0) begin
        mx[a_rd] = a_wdata;
        mp[a_rd] = 1'b0;
      end
      if (acc) mp[a_iss_rd] = 1'b1;
    end
  end

  // Compare every cycle, mid-period, against the model
  always @(negedge clk) begin
    int cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) cnt += int'(mp[i]);
    chk("m_pend_cnt", 64'(a_pend_cnt), 64'(cnt));
    chk("m_iss_ready", 64'(a_iss_ready), 64'(m_ready(a_iss_rd)));
    for (int p = 0; p < 2; p++) begin
      logic [4:0]  ad;
      logic [31:0] ed;
      bit          eb;
      ad = a_rs_addr[p*5 +: 5];
      ed = '0;
      eb = 1'b0;
      if (ad != 0) begin
        if (a_we && a_rd == ad) ed = a_wdata;
        else begin
          ed = mx[ad];
          eb = mp[ad];
        end
      end
      chk("m_rs_data", 64'(a_rs_data[p*32 +: 32]), 64'(ed));
      chk("m_rs_busy", 64'(a_rs_busy[p]), 64'(eb));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Outputs while in reset
    #1;
    a_rs_addr = {5'd9, 5'd5};
    #1;
    chk("rst_cnt", 64'(a_pend_cnt), 64'd0);
    chk("rst_ready", 64'(a_iss_ready), 64'd1);
    chk("rst_data", 64'(a_rs_data), 64'd0);
    chk("rst_busy", 64'(a_rs_busy), 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    b_reset = 1'b0;

    // Write then read
    step();
    a_we = 1'b1; a_rd = 5'd5; a_wdata = 32'hDEADBEEF; a_rs_addr = {5'd0, 5'd5};
    step();
    a_we = 1'b0;
    #1;
    chk("wr_p0_data", 64'(a_rs_data[31:0]), 64'hDEADBEEF);
    chk("wr_p0_busy", 64'(a_rs_busy[0]), 64'd0);
    chk("wr_p1_zero", 64'(a_rs_data[63:32]), 64'd0);
    a_we = 1'b1; a_rd = 5'd0; a_wdata = 32'h1234;
    step();
    a_we = 1'b0; a_rs_addr = {5'd5, 5'd0};
    #1;
    chk("x0_zero", 64'(a_rs_data[31:0]), 64'd0);

    // Same-cycle bypass
    a_we = 1'b1; a_rd = 5'd7; a_wdata = 32'hA5A5A5A5; a_rs_addr = {5'd0, 5'd7};
    #1;
    chk("bypass", 64'(a_rs_data[31:0]), 64'hA5A5A5A5);
    chk("bypass_busy", 64'(a_rs_busy[0]), 64'd0);
    step();
    a_we = 1'b0;

    // Issue, WAW stall, retire
    a_iss_valid = 1'b1; a_iss_rd = 5'd3; a_rs_addr = {5'd0, 5'd3};
    step();
    #1;
    chk("waw_stall", 64'(a_iss_ready), 64'd0);
    chk("iss_cnt", 64'(a_pend_cnt), 64'd1);
    chk("iss_busy", 64'(a_rs_busy[0]), 64'd1);
    a_iss_valid = 1'b0; a_we = 1'b1; a_rd = 5'd3; a_wdata = 32'd9;
    step();
    a_we = 1'b0;
    #1;
    chk("ret_data", 64'(a_rs_data[31:0]), 64'd9);
    chk("ret_busy", 64'(a_rs_busy[0]), 64'd0);
    chk("ret_cnt", 64'(a_pend_cnt), 64'd0);

    // Same-edge issue and write to a pending register
    a_iss_valid = 1'b1; a_iss_rd = 5'd4;
    step();
    a_we = 1'b1; a_rd = 5'd4; a_wdata = 32'h11;
    #1;
    chk("same_ready", 64'(a_iss_ready), 64'd1);
    step();
    a_we = 1'b0; a_iss_valid = 1'b0; a_rs_addr = {5'd0, 5'd4};
    #1;
    chk("same_data", 64'(a_rs_data[31:0]), 64'h11);
    chk("same_busy", 64'(a_rs_busy[0]), 64'd1);
    chk("same_cnt", 64'(a_pend_cnt), 64'd1);

    // Reset in the middle of a cycle
    a_we = 1'b1; a_rd = 5'd4; a_wdata = 32'h22;
    step();
    a_we = 1'b0; a_iss_valid = 1'b1; a_iss_rd = 5'd1;
    step();
    a_iss_rd = 5'd2;
    step();
    a_iss_rd = 5'd3;
    step();
    a_iss_valid = 1'b0; a_rs_addr = {5'd2, 5'd1};
    #1;
    chk("pre_rst_cnt", 64'(a_pend_cnt), 64'd3);
    reset = 1'b1;
    #1;
    chk("mid_rst_cnt", 64'(a_pend_cnt), 64'd0);
    chk("mid_rst_busy", 64'(a_rs_busy), 64'd0);
    chk("mid_rst_data", 64'(a_rs_data), 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Random traffic checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      step();
      a_we        = ($urandom_range(0, 1) == 1);
      a_rd        = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a_wdata     = $urandom;
      a_iss_valid = ($urandom_range(0, 9) < 6);
      a_iss_rd    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a_rs_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      if ($urandom_range(0, 299) == 0) begin
        #2;
        reset = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;
      end
    end
    step();
    a_we = 1'b0; a_iss_valid = 1'b0;

    // Swept instance: fill registers, no-bypass, four-port read
    for (int i = 0; i < 16; i++) begin
      b_we = 1'b1; b_rd = 4'(i); b_wdata = BASE + 64'(i);
      step();
    end
    b_rd = 4'd7; b_wdata = 64'hFFFF_FFFF_FFFF_FFFF; b_rs_addr = {4'd0, 4'd0, 4'd0, 4'd7};
    #1;
    chk("nobypass", b_rs_data[63:0], BASE + 64'd7);
    step();
    b_we = 1'b0; b_rs_addr = {4'd15, 4'd9, 4'd3, 4'd0};
    #1;
    chk("sw_p0_r0", b_rs_data[63:0], BASE);
    chk("sw_p1_r3", b_rs_data[127:64], BASE + 64'd3);
    chk("sw_p2_r9", b_rs_data[191:128], BASE + 64'd9);
    chk("sw_p3_r15", b_rs_data[255:192], BASE + 64'd15);
    b_iss_valid = 1'b1;
    for (int i = 1; i < 16; i++) begin
      b_iss_rd = 4'(i);
      step();
    end
    b_iss_valid = 1'b0;
    #1;
    chk("sw_cnt15", 64'(b_pend_cnt), 64'd15);
    b_we = 1'b1; b_rd = 4'd5; b_wdata = 64'd1; b_rs_addr = {4'd0, 4'd0, 4'd5, 4'd0};
    #1;
    chk("sw_nb_busy", 64'(b_rs_busy[1]), 64'd1);
    chk("sw_nb_data", b_rs_data[127:64], BASE + 64'd5);
    step();
    b_we = 1'b0;
    #1;
    chk("sw_cnt14", 64'(b_pend_cnt), 64'd14);
    b_iss_valid = 1'b1; b_iss_rd = 4'd0;
    step();
    b_iss_rd = 4'd5;
    step();
    b_iss_valid = 1'b0;
    #1;
    chk("sw_cnt16", 64'(b_pend_cnt), 64'd16);
    chk("sw_r0_busy", 64'(b_rs_busy[0]), 64'd1);

    @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
